seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Parametrised N-digit multiplexed seven-segment driver with an internal sequential binary-to-BCD converter.
//  It accepts a binary value through a valid/ready handshake and converts it with an iterative double-dabble FSM.
//  The converted digits are latched into a display register, and a prescaled counter scans the digits onto shared cathodes.
//  Sits between the CPU output/debug register path and the board's anodes/segments.
// PARAMETERS
//  NUM_DIGITS  4   number of display digits (2..8)
//  BIN_WIDTH   13  width of the binary input value
//  PRESCALE_W  18  each digit is shown for 2^PRESCALE_W clk cycles
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  rst        in   1             synchronous reset, active-high
//  num_valid  in   1             num is valid this cycle
//  num        in   BIN_WIDTH     binary value to display
//  hex_mode   in   1             sampled with num: 1 = show hex nibbles, 0 = show decimal
//  num_ready  out  1             converter idle; a value can be accepted
//  conv_done  out  1             one-cycle pulse when the display register updates
//  anode      out  NUM_DIGITS    active-low digit enables; MSB = most significant digit
//  seg        out  7             active-low segments {a,b,c,d,e,f,g}
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, display digits=0, overflow=0, prescaler=0, scan index=NUM_DIGITS-1,
//    anode=all 1s, seg=7'b1111111, num_ready=1, conv_done=0. Reset mid-conversion aborts the conversion; the captured value is discarded.
//  Handshake: accept occurs on a rising edge with num_valid&&num_ready; num and hex_mode are captured.
//    num_ready=(state==IDLE). num_valid while busy is ignored, not queued.
//  FSM:
//    IDLE -accept-> hex_mode ? UPDATE : SHIFT.
//    SHIFT runs BIN_WIDTH cycles; each cycle adds 3 to every BCD nibble >=5, then shifts left 1 bit, taking in the next input bit, MSB first.
//    SHIFT -last bit-> UPDATE.
//    UPDATE (1 cycle): copy the digits to the display register, pulse conv_done, then -> IDLE.
//  Latency:
//    Decimal: accept at edge k -> display register and conv_done at edge k+BIN_WIDTH+1.
//    Hex: accept at edge k -> display register and conv_done at edge k+1.
//  Overflow, set at capture:
//    Decimal: num >= 10^NUM_DIGITS.
//    Hex: any bit of num at or above bit 4*NUM_DIGITS is set.
//    Overflow forces every digit glyph to "-" (7'b1111110) until the next update.
//  Hex nibbles: digit i = num[4i+3:4i], zero-extended when BIN_WIDTH < 4*NUM_DIGITS.
//  Scan:
//    The prescaler free-runs.
//    On wrap: scan index decrements; 0 wraps to NUM_DIGITS-1.
//    anode/seg are registered, one cycle after the index change: anode has one zero at bit=index; seg=glyph(display[index]).
//    The display updates mid-scan; the new value appears on the next registered cycle with no blanking glitch.
//  Glyphs:
//    Digits: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
//    Letters: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
//  Simultaneous accept with prescaler wrap: both take effect independently.
// CONFIGURATION
//  SEVSEG_LEADING_ZERO_BLANK_EN defined:
//    Leading zero digits above the most significant nonzero digit are blanked (seg=7'b1111111); their anode still strobes.
//    Value 0 shows a single "0" in digit 0.
//    Overflow dashes are never blanked.
//  Undefined: every digit shows its glyph, including leading zeros.
// TESTING
//  1. Reset, then idle: anode=all 1s, seg=7'b1111111 for 1 cycle after rst; then digit 3 on, seg=0000001; num_ready=1.
//  2. Decimal num=1234 (NUM_DIGITS=4): conv_done exactly 14 cycles after accept; scan shows 1,2,3,4 on anode 0111,1011,1101,1110.
//  3. Hex num=13'h1ABC, hex_mode=1: conv_done at the next edge; digits 1,A,b,C.
//  4. Decimal num=8191 (> 9999? no, valid) then num=10000 with BIN_WIDTH=14: first shows 8191; second shows "----".
//  5. num_valid held during SHIFT: no second accept; rst asserted mid-SHIFT -> display 0000, num_ready=1 next cycle.
//  6. With SEVSEG_LEADING_ZERO_BLANK_EN: num=42 -> digits 3,2 blank, digits 1,0 show 4,2; num=0 -> only digit 0 shows "0".

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// N-digit multiplexed seven-segment driver with a sequential double-dabble binary-to-BCD converter.
// Optional build macro SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scan_driver #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BIN_WIDTH  = 13,
   parameter int unsigned PRESCALE_W = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  num_valid,
   input  logic [BIN_WIDTH-1:0]  num,
   input  logic                  hex_mode,
   output logic                  num_ready,
   output logic                  conv_done,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [6:0]            seg
);

   localparam int unsigned DIG_W  = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W  = $clog2(BIN_WIDTH + 1);
   localparam int unsigned WIDE_W = (BIN_WIDTH > 40) ? BIN_WIDTH : 40;

   function automatic logic [WIDE_W-1:0] pow10(input int unsigned n);
      logic [WIDE_W-1:0] p;
      p = WIDE_W'(1);
      for (int unsigned i = 0; i < n; i++) p = p * WIDE_W'(10);
      return p;
   endfunction

   localparam logic [WIDE_W-1:0] DEC_LIMIT = pow10(NUM_DIGITS);

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0: g = 7'b0000001;
         4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;
         4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;
         4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;
         4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0000100;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b1100000;
         4'hC: g = 7'b0110001;
         4'hD: g = 7'b1000010;
         4'hE: g = 7'b0110000;
         default: g = 7'b0111000;
      endcase
      return g;
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

   state_t                     state_q, state_d;
   logic [BIN_WIDTH-1:0]       shreg_q, shreg_d;
   logic [DIG_W-1:0]           bcd_q, bcd_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       ovf_pend_q, ovf_pend_d;
   logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
   logic                       disp_ovf_q, disp_ovf_d;
   logic                       conv_done_q, conv_done_d;
   logic [PRESCALE_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [NUM_DIGITS-1:0]      anode_q, anode_d;
   logic [6:0]                 seg_q, seg_d;

   logic [DIG_W-1:0]           bcd_adj;
   logic [WIDE_W-1:0]          num_wide;
   logic [NUM_DIGITS-1:0]      blank;
   logic                       accept;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
   logic                       lz_seen;
`endif

   assign num_ready = (state_q == IDLE);
   assign accept    = num_valid && num_ready;
   assign num_wide  = WIDE_W'(num);

   // Converter: hex values bypass the shift phase and go straight to UPDATE.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      ovf_pend_d  = ovf_pend_q;
      disp_d      = disp_q;
      disp_ovf_d  = disp_ovf_q;
      conv_done_d = 1'b0;

      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d = num;
               cnt_d   = CNT_W'(BIN_WIDTH - 1);
               if (hex_mode) begin
                  bcd_d      = DIG_W'(num_wide);
                  ovf_pend_d = (num_wide >> DIG_W) != '0;
                  state_d    = UPDATE;
               end else begin
                  bcd_d      = '0;
                  ovf_pend_d = (num_wide >= DEC_LIMIT);
                  state_d    = SHIFT;
               end
            end
         end
         SHIFT: begin
            // Digits above NUM_DIGITS fall off the top; overflow already covers that case.
            bcd_d   = DIG_W'({bcd_adj, shreg_q[BIN_WIDTH-1]});
            shreg_d = shreg_q << 1;
            if (cnt_q == '0) state_d = UPDATE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         UPDATE: begin
            disp_d      = bcd_q;
            disp_ovf_d  = ovf_pend_q;
            conv_done_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == '1) begin
         idx_d = (idx_q == '0) ? IDX_W'(NUM_DIGITS - 1) : idx_q - 1'b1;
      end

      blank = '0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      // Digit 0 is never blanked so a zero value still shows a single "0".
      lz_seen = 1'b0;
      for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
         lz_seen  = lz_seen | (disp_q[i] != 4'd0);
         blank[i] = !lz_seen && !disp_ovf_q;
      end
`endif

      anode_d = ~(NUM_DIGITS'(1) << idx_q);
      if (disp_ovf_q)          seg_d = 7'b1111110;
      else if (blank[idx_q])   seg_d = 7'b1111111;
      else                     seg_d = glyph(disp_q[idx_q]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         ovf_pend_q  <= 1'b0;
         disp_q      <= '0;
         disp_ovf_q  <= 1'b0;
         conv_done_q <= 1'b0;
         presc_q     <= '0;
         idx_q       <= IDX_W'(NUM_DIGITS - 1);
         anode_q     <= '1;
         seg_q       <= '1;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         ovf_pend_q  <= ovf_pend_d;
         disp_q      <= disp_d;
         disp_ovf_q  <= disp_ovf_d;
         conv_done_q <= conv_done_d;
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         anode_q     <= anode_d;
         seg_q       <= seg_d;
      end
   end

   assign conv_done = conv_done_q;
   assign anode     = anode_q;
   assign seg       = seg_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: stimulus pushes expected glyphs and completion
// cycle; a monitor pops on conv_done and checks latency and the scanned anode/segment pattern.
module tb_seven_seg_scan_driver;

   localparam int unsigned ND    = 4;
   localparam int unsigned BW    = 18;
   localparam int unsigned PW    = 3;
   localparam int unsigned DWELL = 1 << PW;

   logic          clk = 1'b0;
   logic          rst;
   logic          num_valid;
   logic [BW-1:0] num;
   logic          hex_mode;
   logic          num_ready;
   logic          conv_done;
   logic [ND-1:0] anode;
   logic [6:0]    seg;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   seven_seg_scan_driver #(
      .NUM_DIGITS (ND),
      .BIN_WIDTH  (BW),
      .PRESCALE_W (PW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .num_valid (num_valid),
      .num       (num),
      .hex_mode  (hex_mode),
      .num_ready (num_ready),
      .conv_done (conv_done),
      .anode     (anode),
      .seg       (seg)
   );

   typedef logic [ND-1:0][6:0] segs_t;
   typedef struct {
      int unsigned due;
      int unsigned val;
      segs_t       segs;
   } exp_t;

   exp_t exp_q[$];

   logic [6:0] glyph_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected per-digit segment pattern from plain arithmetic on the value.
   function automatic segs_t model(input int unsigned v, input bit h);
      int unsigned d[ND];
      int unsigned p;
      bit          ovf;
      int          top;
      segs_t       s;
      p = 1;
      for (int i = 0; i < ND; i++) begin
         d[i] = h ? ((v >> (4 * i)) & 15) : ((v / p) % 10);
         p    = p * 10;
      end
      ovf = h ? ((v >> (4 * ND)) != 0) : (v >= p);
      top = 0;
      for (int i = 0; i < ND; i++) if (d[i] != 0) top = i;
      for (int i = 0; i < ND; i++) begin
         if (ovf) s[i] = 7'b1111110;
         else begin
            s[i] = glyph_tab[d[i]];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
            if (i > top) s[i] = 7'b1111111;
`endif
         end
      end
      return s;
   endfunction

   task automatic do_reset(input string tag);
      segs_t z;
      z = model(0, 1'b0);
      rst = 1'b1;
      num_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_anode"}, anode, 4'hF);
      check({tag, "_seg"}, seg, 7'h7F);
      check({tag, "_ready"}, num_ready, 1'b1);
      check({tag, "_conv_done"}, conv_done, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check({tag, "_first_anode"}, anode, 4'b0111);
      check({tag, "_first_seg"}, seg, z[ND-1]);
      check({tag, "_ready_after"}, num_ready, 1'b1);
   endtask

   task automatic send(input int unsigned v, input bit h, input bit hold);
      int unsigned lat;
      int unsigned t;
      bit          busy_ok;
      exp_t        e;
      lat = h ? 1 : BW + 1;
      num = BW'(v);
      hex_mode = h;
      num_valid = 1'b1;
      t = 0;
      while (!num_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("ready_before_accept", num_ready, 1'b1);
      e.due  = cyc + 1 + lat;
      e.val  = v;
      e.segs = model(v, h);
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (!hold) num_valid = 1'b0;
      busy_ok = 1'b1;
      for (int i = 0; i < int'(lat); i++) begin
         if (hold) begin
            num = BW'($urandom);
            hex_mode = 1'($urandom_range(0, 1));
         end
         if (num_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk); #1;
      end
      num_valid = 1'b0;
      check("busy_not_ready", busy_ok, 1'b1);
      check("ready_after_update", num_ready, 1'b1);
      repeat (40) @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t  e;
      segs_t got;
      logic [ND-1:0] seen;
      int    idx, prev, run;
      bit    scan_ok, first_done;
      forever begin
         @(negedge clk);
         if (rst || !conv_done) continue;
         if (exp_q.size() == 0) begin
            check("conv_done_unexpected", conv_done, 1'b0);
            continue;
         end
         e = exp_q.pop_front();
         check($sformatf("latency_%0h", e.val), cyc, e.due);
         got = '0; seen = '0; prev = -1; run = 0; scan_ok = 1'b1; first_done = 1'b0;
         for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            idx = -1;
            for (int i = 0; i < ND; i++) if (anode == ~(ND'(1) << i)) idx = i;
            if (idx < 0) scan_ok = 1'b0;
            else begin
               got[idx]  = seg;
               seen[idx] = 1'b1;
               if (idx == prev) run++;
               else begin
                  if (prev >= 0) begin
                     if (idx != (prev + ND - 1) % ND) scan_ok = 1'b0;
                     if (first_done && run != int'(DWELL)) scan_ok = 1'b0;
                     first_done = 1'b1;
                  end
                  run  = 1;
                  prev = idx;
               end
            end
         end
         check($sformatf("scan_order_%0h", e.val), scan_ok, 1'b1);
         check($sformatf("scan_all_%0h", e.val), seen, {ND{1'b1}});
         for (int i = 0; i < ND; i++)
            check($sformatf("digit%0d_of_%0h", i, e.val), got[i], e.segs[i]);
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin : stimulus
      int unsigned v;
      bit          h;
      rst = 1'b1;
      num_valid = 1'b0;
      num = '0;
      hex_mode = 1'b0;
      do_reset("reset");

      send(1234, 1'b0, 1'b0);

      // Abort a decimal conversion mid-shift; display must return to zero.
      num = BW'(5678);
      hex_mode = 1'b0;
      num_valid = 1'b1;
      check("abort_ready", num_ready, 1'b1);
      @(posedge clk); #1;
      num_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      do_reset("abort");
      repeat (BW + 5) @(posedge clk);
      #1;

      send(32'h1ABC, 1'b1, 1'b0);
      send(8191, 1'b0, 1'b1);
      send(10000, 1'b0, 1'b0);
      send(9999, 1'b0, 1'b0);
      send(42, 1'b0, 1'b0);
      send(0, 1'b0, 1'b0);
      send(32'h30000, 1'b1, 1'b0);
      send(32'h0, 1'b1, 1'b0);
      send(32'hFFFF, 1'b1, 1'b1);
      repeat (12) begin
         h = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) v = $urandom_range(0, (1 << BW) - 1);
         else                           v = $urandom_range(0, 9999);
         send(v, h, 1'($urandom_range(0, 1)));
      end
      repeat (5) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
